bcd_timer_counter: RTL and testbench
====================================

BCD_TIMER_COUNTER -- requirements
Module: bcd_timer_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 1: tick pulses per count increment, legal range 1..1024.
REQ-003 SHALL have port clk, in, 1: single rising-edge clock for all state.
REQ-004 SHALL have port rst_n, in, 1: asynchronous active-low reset.
REQ-005 SHALL have port tick, in, 1: count-enable strobe, sampled each clk.
REQ-006 SHALL have port start, in, 1: begin timing.
REQ-007 SHALL have port stop, in, 1: capture and freeze.
REQ-008 SHALL have port clear, in, 1: synchronous return to idle.
REQ-009 SHALL have port count, out, 4*DIGITS: live BCD value, digit 0 in bits [3:0].
REQ-010 SHALL have port result, out, 4*DIGITS: captured BCD value.
REQ-011 SHALL have port result_valid, out, 1: high while result holds a capture.
REQ-012 SHALL have port running, out, 1: high in RUN.
REQ-013 SHALL have port carry_out, out, 1: one-cycle pulse on full-scale increment.
REQ-014 SHALL have port overflow, out, 1: sticky full-scale flag.

Function
REQ-015 SHALL implement states IDLE, RUN and HOLD; running=1 only in RUN.
REQ-016 Per-cycle input priority SHALL be clear > stop > start > tick.
REQ-017 clear in any state SHALL zero count, result, result_valid, overflow and prescaler, and enter IDLE next cycle.
REQ-018 start in IDLE or HOLD SHALL zero count, prescaler, overflow and result_valid, and enter RUN; result keeps its value.
REQ-019 start in RUN SHALL be ignored; stop in IDLE or HOLD SHALL be ignored.
REQ-020 In RUN, each tick SHALL advance a prescaler 0..TICK_DIV-1; a tick with the prescaler at TICK_DIV-1 SHALL wrap it to 0 and increment count by one, visible the next cycle.
REQ-021 Increment SHALL be decimal: a digit at 9 goes to 0 and carries into the next digit in the same cycle; no digit SHALL ever hold 10..15.
REQ-022 stop in RUN SHALL copy the current count register (pre-increment; any coincident tick is discarded) into result, set result_valid=1, and enter HOLD.
REQ-023 In HOLD, count SHALL stay frozen and ticks SHALL be ignored.
REQ-024 Full scale is every digit at 9; an increment at full scale SHALL pulse carry_out for exactly one cycle and set overflow=1.
REQ-025 carry_out SHALL be registered and SHALL be 0 in every other cycle.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, and zero the prescaler, count, result, result_valid, running, carry_out and overflow.
REQ-027 Reset asserted mid-RUN SHALL abandon the measurement; result is not preserved.
REQ-028 After rst_n deasserts, the first start SHALL be honoured on the first rising clk edge.

Configuration
REQ-029 Macro BCD_SATURATE_EN defined: an increment at full scale SHALL hold count at all-9s, pulse carry_out once and set overflow; later ticks change nothing; state stays RUN until stop or clear.
REQ-030 Macro BCD_SATURATE_EN undefined: an increment at full scale SHALL wrap count to all-0s, pulse carry_out and set overflow; counting continues.

Verification
REQ-031 DIGITS=4, TICK_DIV=1: reset, start, 137 ticks, stop -> result=0x0137, result_valid=1, running=0.
REQ-032 TICK_DIV=10: start, 25 ticks -> count=0x0002; prescaler=5 and no count change on the 25th tick.
REQ-033 DIGITS=2, start, 99 ticks, then 1 tick -> 0x99; then one-cycle carry_out, overflow=1, count=0x99 with BCD_SATURATE_EN and 0x00 without.
REQ-034 stop and tick in the same cycle with count=0x0041 -> result=0x0041, count frozen at 0x0041.
REQ-035 rst_n low mid-RUN between clk edges -> all outputs 0 immediately, state IDLE; clear with stop and start asserted together -> IDLE, result_valid=0.

Source files
------------

// File: rtl/bcd_timer_counter.sv
// Cascaded BCD stopwatch counter with tick prescaler, capture register and overflow flag.
// Optional macro BCD_SATURATE_EN: hold count at full scale instead of wrapping to zero.
module bcd_timer_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   result,
    output logic                  result_valid,
    output logic                  running,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  ALL9 = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [W-1:0]  inc;
    logic          cy;

    // Decimal +1 across all digits with a ripple carry.
    always_comb begin
        inc = count;
        cy  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cy) begin
                if (count[4*i +: 4] == 4'h9) begin
                    inc[4*i +: 4] = 4'h0;
                end else begin
                    inc[4*i +: 4] = count[4*i +: 4] + 4'h1;
                    cy            = 1'b0;
                end
            end
        end
    end

    // Control FSM with prescaler, counter, capture and flags, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prescaler    <= '0;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            running      <= 1'b0;
            carry_out    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            carry_out <= 1'b0;
            if (clear) begin
                state        <= IDLE;
                running      <= 1'b0;
                prescaler    <= '0;
                count        <= '0;
                result       <= '0;
                result_valid <= 1'b0;
                overflow     <= 1'b0;
            end else if (stop && state == RUN) begin
                state        <= HOLD;
                running      <= 1'b0;
                result       <= count;
                result_valid <= 1'b1;
            end else if (start && state != RUN) begin
                state        <= RUN;
                running      <= 1'b1;
                prescaler    <= '0;
                count        <= '0;
                overflow     <= 1'b0;
                result_valid <= 1'b0;
            end else if (start) begin
                // A repeated start while timing leaves everything untouched.
                state <= RUN;
            end else if (tick && state == RUN) begin
                if (prescaler == PMAX) begin
                    prescaler <= '0;
                    if (count == ALL9) begin
`ifdef BCD_SATURATE_EN
                        if (!overflow) begin
                            carry_out <= 1'b1;
                        end
`else
                        carry_out <= 1'b1;
                        count     <= '0;
`endif
                        overflow <= 1'b1;
                    end else begin
                        count <= inc;
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench: vector table on a 4-digit counter plus corner sequences
// on a divide-by-10 instance and a 2-digit instance sharing the same inputs.
module tb_bcd_timer_counter;

    logic clk;
    logic rst_n;
    logic tick;
    logic start;
    logic stop;
    logic clear;

    logic [15:0] a_count;
    logic [15:0] a_result;
    logic        a_valid;
    logic        a_running;
    logic        a_carry;
    logic        a_ovf;

    logic [15:0] b_count;
    logic [15:0] b_result;
    logic        b_valid;
    logic        b_running;
    logic        b_carry;
    logic        b_ovf;

    logic [7:0]  c_count;
    logic [7:0]  c_result;
    logic        c_valid;
    logic        c_running;
    logic        c_carry;
    logic        c_ovf;

    int tests;
    int fails;

    bcd_timer_counter #(.DIGITS(4), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .stop(stop), .clear(clear), .count(a_count), .result(a_result),
        .result_valid(a_valid), .running(a_running),
        .carry_out(a_carry), .overflow(a_ovf)
    );

    bcd_timer_counter #(.DIGITS(4), .TICK_DIV(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .stop(stop), .clear(clear), .count(b_count), .result(b_result),
        .result_valid(b_valid), .running(b_running),
        .carry_out(b_carry), .overflow(b_ovf)
    );

    bcd_timer_counter #(.DIGITS(2), .TICK_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .stop(stop), .clear(clear), .count(c_count), .result(c_result),
        .result_valid(c_valid), .running(c_running),
        .carry_out(c_carry), .overflow(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        clr;
        logic        stp;
        logic        sta;
        logic        tck;
        logic [15:0] cnt;
        logic [15:0] res;
        logic        val;
        logic        run;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic sp, input logic st,
                        input logic tk);
        clear = c;
        stop  = sp;
        start = st;
        tick  = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        rst_n = 1'b1;
        #2;

        //         clr   stp   sta   tck   cnt      res      val   run   co    ov
        vecs[0]  = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = {1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = {1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = {1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = {1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = {1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();
        check("reset_count", a_count, 0);
        check("reset_result", a_result, 0);
        check("reset_valid", a_valid, 0);
        check("reset_running", a_running, 0);
        check("reset_carry", a_carry, 0);
        check("reset_ovf", a_ovf, 0);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].clr, vecs[i].stp, vecs[i].sta, vecs[i].tck);
            check($sformatf("vec%0d_count", i), a_count, vecs[i].cnt);
            check($sformatf("vec%0d_result", i), a_result, vecs[i].res);
            check($sformatf("vec%0d_valid", i), a_valid, vecs[i].val);
            check($sformatf("vec%0d_running", i), a_running, vecs[i].run);
            check($sformatf("vec%0d_carry", i), a_carry, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), a_ovf, vecs[i].ov);
        end

        // 137 ticks at divide-by-1, including decimal rollovers
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(10);
        check("dec_rollover_10", a_count, 16'h0010);
        ticks(90);
        check("dec_rollover_100", a_count, 16'h0100);
        ticks(37);
        check("count_137", a_count, 16'h0137);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run137_result", a_result, 16'h0137);
        check("run137_valid", a_valid, 1);
        check("run137_running", a_running, 0);

        // Divide-by-10 prescaler
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(9);
        check("div10_9ticks", b_count, 16'h0000);
        ticks(1);
        check("div10_10ticks", b_count, 16'h0001);
        ticks(14);
        check("div10_24ticks", b_count, 16'h0002);
        ticks(1);
        check("div10_25ticks", b_count, 16'h0002);
        ticks(4);
        check("div10_29ticks", b_count, 16'h0002);
        ticks(1);
        check("div10_30ticks", b_count, 16'h0003);

        // Two-digit full-scale increment
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(99);
        check("fs_count99", c_count, 8'h99);
        check("fs_pre_carry", c_carry, 0);
        check("fs_pre_ovf", c_ovf, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("fs_carry_pulse", c_carry, 1);
        check("fs_ovf_set", c_ovf, 1);
`ifdef BCD_SATURATE_EN
        check("fs_count_after", c_count, 8'h99);
`else
        check("fs_count_after", c_count, 8'h00);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("fs_carry_one_cycle", c_carry, 0);
        check("fs_ovf_sticky", c_ovf, 1);
        check("fs_running", c_running, 1);
`ifdef BCD_SATURATE_EN
        check("fs_count_next", c_count, 8'h99);
`else
        check("fs_count_next", c_count, 8'h01);
`endif
        check("fs_ovf_other_dut", a_ovf, 0);

        // Stop coincident with tick discards the tick
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(41);
        check("stoptick_pre", a_count, 16'h0041);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("stoptick_result", a_result, 16'h0041);
        check("stoptick_count", a_count, 16'h0041);
        ticks(3);
        check("hold_frozen", a_count, 16'h0041);

        // Asynchronous reset mid-RUN, between edges
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(5);
        check("midrun_count", a_count, 16'h0005);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", a_count, 0);
        check("arst_result", a_result, 0);
        check("arst_valid", a_valid, 0);
        check("arst_running", a_running, 0);
        check("arst_carry", a_carry, 0);
        check("arst_ovf", a_ovf, 0);
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("first_start_honoured", a_running, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_valid", a_valid, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_all_running", a_running, 0);
        check("clr_all_valid", a_valid, 0);
        check("clr_all_result", a_result, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_idle_count", a_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
